// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU, state and fault encodings for the 16-bit CPU control path
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_BEQZ = 4'd7,
        OP_JMP  = 4'd8,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_PASS_A = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_BUS     = 2'b10
    } fault_e;

    typedef logic [2:0] seq_state_e;
    localparam seq_state_e ST_IDLE   = 3'd0;
    localparam seq_state_e ST_FETCH  = 3'd1;
    localparam seq_state_e ST_DECODE = 3'd2;
    localparam seq_state_e ST_EXEC   = 3'd3;
    localparam seq_state_e ST_MEM    = 3'd4;
    localparam seq_state_e ST_WB     = 3'd5;
    localparam seq_state_e ST_HALT   = 3'd6;

    localparam int IR_OP_MSB   = 15;
    localparam int IR_OP_LSB   = 12;
    localparam int IR_RD_MSB   = 11;
    localparam int IR_RD_LSB   = 9;
    localparam int IR_RS_MSB   = 8;
    localparam int IR_RS_LSB   = 6;
    localparam int IR_IMM_MODE = 5;
    localparam int IR_IMM_MSB  = 4;
    localparam int IR_IMM_LSB  = 0;

    typedef struct packed {
        logic    is_alu;
        logic    is_ld;
        logic    is_st;
        logic    is_br;
        logic    is_jmp;
        logic    is_halt;
        logic    illegal;
        alu_op_e alu_op;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode classifier feeding the sequencer
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec.is_alu = 1'b1;
                dec.alu_op = alu_op_e'(opcode[2:0]);
            end
            OP_LD:   dec.is_ld   = 1'b1;
            OP_ST:   dec.is_st   = 1'b1;
            OP_BEQZ: begin
                dec.is_br  = 1'b1;
                dec.alu_op = ALU_PASS_A;
            end
            OP_JMP:  dec.is_jmp  = 1'b1;
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        halted,
    output logic [1:0]  fault
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    seq_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [1:0]        fault_q, fault_d;
    dec_t              dec;
    logic              unused_ir_bits;

    instr_decoder u_decoder (
        .opcode (ir[IR_OP_MSB:IR_OP_LSB]),
        .dec    (dec)
    );

    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_ir_bits = ^{ir[IR_RD_MSB:IR_RS_LSB], ir[IR_IMM_MSB:IR_IMM_LSB]};
    assign wait_inc       = wait_q + WAIT_W'(1);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH, ST_MEM: begin
                if (mem_ready) begin
                    wait_d = '0;
                    if (state_q == ST_FETCH)  state_d = ST_DECODE;
                    else if (dec.is_ld)       state_d = ST_WB;
                    else                      state_d = ST_FETCH;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_MAX) begin
                        fault_d = FAULT_BUS;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
                if (dec.illegal) begin
                    fault_d = FAULT_ILLEGAL;
                    state_d = ST_HALT;
                end else if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_ld || dec.is_st) state_d = ST_MEM;
                else if (dec.is_alu)        state_d = ST_WB;
                else                        state_d = ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
        // A fresh memory request always starts its timeout window from zero.
        if (state_d != state_q && (state_d == ST_FETCH || state_d == ST_MEM)) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            ST_EXEC: begin
                if (dec.is_alu) begin
                    alu_op      = dec.alu_op;
                    alu_src_imm = ir[IR_IMM_MODE];
                end else if (dec.is_ld || dec.is_st) begin
                    alu_src_imm = 1'b1;
                end else if (dec.is_br) begin
                    alu_op  = ALU_PASS_A;
                    pc_load = zero;
                end else if (dec.is_jmp) begin
                    pc_load = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                addr_sel    = 1'b1;
                alu_src_imm = 1'b1;
                mem_we      = dec.is_st;
            end
            ST_WB: begin
                reg_we = 1'b1;
                wb_sel = dec.is_ld;
                if (dec.is_alu) begin
                    alu_op      = dec.alu_op;
                    alu_src_imm = ir[IR_IMM_MODE];
                end
            end
            default: ;
        endcase
    end

    assign halted = (state_q == ST_HALT);
    assign fault  = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized per-instruction schedule checks for instr_sequencer
module tb_instr_sequencer;

    localparam int WAIT_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [2:0]  alu_op;
    logic        alu_src_imm, reg_we, wb_sel, halted;
    logic [1:0]  fault;
    logic [14:0] got_v;

    int n_checks = 0;
    int n_pass   = 0;

    instr_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .WAIT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .ir          (ir),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .fault       (fault)
    );

    assign got_v = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                    alu_op, alu_src_imm, reg_we, wb_sel, halted, fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [14:0] ov(input bit req, we, asel, irl, pci, pcl,
                                       input logic [2:0] op,
                                       input bit imm, rwe, wbs, hlt,
                                       input logic [1:0] flt);
        return {req, we, asel, irl, pci, pcl, op, imm, rwe, wbs, hlt, flt};
    endfunction

    // Inputs are set just after a rising edge; outputs are checked mid-cycle.
    task automatic cyc(input string tag, input logic [14:0] exp);
        #2;
        check(tag, 32'(got_v), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        mem_ready = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b0;
        noise();
        cyc("idle", '0);
        run = 1'b1;
        cyc("idle_run", '0);
    endtask

    task automatic halt_hold(input logic [1:0] f);
        for (int i = 0; i < 3; i++) begin
            run = (i % 2 == 0);
            noise();
            cyc("halt_hold", ov(0,0,0,0,0,0,3'd0,0,0,0,1,f));
        end
    endtask

    // Reference schedule for one instruction, starting in FETCH.
    task automatic run_instr(input logic [15:0] instr, input int wf, input int wm, input bit z,
                             output bit h, output logic [1:0] f);
        logic [3:0] opc;
        opc = instr[15:12];
        h   = 1'b0;
        f   = 2'b00;
        run = 1'($urandom_range(0, 1));
        for (int i = 0; i < wf && i < WAIT_LIMIT; i++) begin
            mem_ready = 1'b0;
            cyc("fetch_wait", ov(1,0,0,0,0,0,3'd0,0,0,0,0,2'b00));
        end
        if (wf >= WAIT_LIMIT) begin
            h = 1'b1; f = 2'b10; return;
        end
        mem_ready = 1'b1;
        cyc("fetch", ov(1,0,0,1,1,0,3'd0,0,0,0,0,2'b00));
        ir = instr;
        noise();
        cyc("decode", '0);
        if (opc == 4'd15) begin
            h = 1'b1; return;
        end
        if (opc >= 4'd9) begin
            h = 1'b1; f = 2'b01; return;
        end
        noise();
        if (opc <= 4'd4) begin
            cyc("exec_alu", ov(0,0,0,0,0,0,opc[2:0],instr[5],0,0,0,2'b00));
            noise();
            cyc("wb_alu", ov(0,0,0,0,0,0,opc[2:0],instr[5],1,0,0,2'b00));
        end else if (opc == 4'd5 || opc == 4'd6) begin
            cyc("exec_mem", ov(0,0,0,0,0,0,3'd0,1,0,0,0,2'b00));
            for (int i = 0; i < wm && i < WAIT_LIMIT; i++) begin
                mem_ready = 1'b0;
                cyc("mem_wait", ov(1,opc == 4'd6,1,0,0,0,3'd0,1,0,0,0,2'b00));
            end
            if (wm >= WAIT_LIMIT) begin
                h = 1'b1; f = 2'b10; return;
            end
            mem_ready = 1'b1;
            cyc("mem", ov(1,opc == 4'd6,1,0,0,0,3'd0,1,0,0,0,2'b00));
            if (opc == 4'd5) begin
                noise();
                cyc("wb_ld", ov(0,0,0,0,0,0,3'd0,0,1,1,0,2'b00));
            end
        end else if (opc == 4'd7) begin
            zero = z;
            cyc("exec_beqz", ov(0,0,0,0,0,z,3'd5,0,0,0,0,2'b00));
        end else begin
            cyc("exec_jmp", ov(0,0,0,0,0,1,3'd0,0,0,0,0,2'b00));
        end
    endtask

    task automatic step(input logic [15:0] instr, input int wf, input int wm, input bit z);
        bit         h;
        logic [1:0] f;
        run_instr(instr, wf, wm, z, h, f);
        if (h) begin
            halt_hold(f);
            do_reset();
        end
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        ir        = 16'h0000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        step(16'h0245, 0, 0, 1'b0);
        step(16'h5A5F, 1, 3, 1'b0);
        step(16'h6A41, 0, 2, 1'b0);
        step(16'h7000, 0, 0, 1'b1);
        step(16'h7000, 2, 0, 1'b0);
        step(16'h8003, 0, 0, 1'b0);
        step(16'h1A02, 3, 0, 1'b0);
        step(16'h9000, 0, 0, 1'b0);
        step(16'h0000, WAIT_LIMIT, 0, 1'b0);
        step(16'h5000, 0, WAIT_LIMIT + 1, 1'b0);
        step(16'hF000, 0, 0, 1'b0);

        // Reset while a memory request is outstanding.
        mem_ready = 1'b1;
        cyc("fetch", ov(1,0,0,1,1,0,3'd0,0,0,0,0,2'b00));
        ir = 16'h5000;
        noise();
        cyc("decode", '0);
        noise();
        cyc("exec_mem", ov(0,0,0,0,0,0,3'd0,1,0,0,0,2'b00));
        mem_ready = 1'b0;
        cyc("mem_wait", ov(1,0,1,0,0,0,3'd0,1,0,0,0,2'b00));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b0;
        cyc("rst_in_mem", '0);
        run = 1'b1;
        cyc("idle_run", '0);
        step(16'h3C40, 3, 0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            logic [3:0] opc;
            int         r, wf, wm;
            r = $urandom_range(0, 19);
            if (r < 17)       opc = 4'(r % 9);
            else if (r == 17) opc = 4'd15;
            else if (r == 18) opc = 4'(9 + $urandom_range(0, 5));
            else              opc = 4'd5;
            wf = ($urandom_range(0, 15) == 0) ? WAIT_LIMIT + $urandom_range(0, 2) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 15) == 0) ? WAIT_LIMIT + $urandom_range(0, 2) : $urandom_range(0, 3);
            step({opc, 12'($urandom)}, wf, wm, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
